secure_serdes_rx_deserializer: RTL and testbench
================================================

# secure_serdes_rx_deserializer

Receive-side stage that sits directly downstream of the secure SerDes encryptor core. It consumes the encryptor's serial cipher bit stream, reassembles it into bytes (MSB first), and XOR-decrypts each byte with a fixed key byte. Recovered bytes are buffered in a small show-ahead FIFO and presented on a valid/ready byte interface. It also flags overflow and stalled (timed-out) partial frames.

## Interface
Parameters:
- `KEY_BYTE`, default 8'h34: decryption key byte; must equal the key byte used by the encryptor.
- `FIFO_DEPTH`, default 4: byte FIFO entries; power of two, 2..16.
- `TIMEOUT`, default 16: idle cycles tolerated mid-byte before the partial byte is discarded; 2..255.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; one clock; asynchronous, active-low.
- `sin` in 1: serial cipher bit.
- `sin_valid` in 1: `sin` is captured on every edge where this is high.
- `sync` in 1: frame align; clears the partial byte.
- `out_data` out 8: FIFO head byte; 8'h00 when empty.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts the head byte.
- `fill` out 5: current FIFO occupancy.
- `overflow` out 1: sticky; a completed byte was dropped because the FIFO was full.
- `frame_err` out 1: sticky; a partial byte was discarded by timeout.
- `clr_err` in 1: clears `overflow` and `frame_err`.

## Operation
- Datapath state: 7-bit shift register, 3-bit `bit_cnt`, 8-bit idle counter, FIFO (read/write pointers plus count).
- FSM states:
  - IDLE (`bit_cnt`=0, no partial byte).
  - SHIFT (1–7 bits held).
- Capture:
  - On an edge with `sin_valid`=1, `sin` shifts into the LSB and `bit_cnt` increments.
  - When the 8th bit arrives, byte = {shift[6:0], sin} ^ KEY_BYTE. It is pushed to the FIFO on that same edge.
  - `bit_cnt` wraps to 0 and the FSM returns to IDLE.
- Push/pop rules:
  - Pop occurs when `out_valid` && `out_ready`.
  - FIFO not full: push always accepted.
  - FIFO full with a simultaneous pop: push accepted, `fill` unchanged.
  - FIFO full with no pop: byte dropped, `overflow` set to 1.
  - Push and pop in the same cycle with a non-full FIFO: `fill` unchanged.
  - Pop on an empty FIFO: ignored.
- Timeout:
  - In SHIFT, each edge with `sin_valid`=0 increments the idle counter; any captured bit resets it to 0.
  - When the counter reaches TIMEOUT: shift register, `bit_cnt` and counter clear, the FSM goes to IDLE, and `frame_err` is set to 1.
  - The idle counter is held at 0 in IDLE.
- Sync:
  - `sync`=1 clears the shift register, `bit_cnt` and idle counter; no error is flagged.
  - If `sin_valid`=1 on the same edge, `sin` is taken as bit 7 (first bit) of a new byte, leaving `bit_cnt`=1.
- Errors:
  - `clr_err`=1 clears both sticky flags.
  - If a set event coincides with `clr_err`, the set wins.
- `out_data` is gated to 8'h00 whenever the FIFO is empty.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `fill`=0, `overflow`=0, `frame_err`=0. FSM in IDLE, all counters and the FIFO cleared.
- Latency: a byte whose 8th bit is captured at edge N has `out_valid`=1 and the byte on `out_data` after edge N (visible in cycle N+1).
- Handshake:
  - `out_data` and `out_valid` are registered/FIFO-derived only, with no combinational path from `out_ready`.
  - The head byte is held stable until popped.
- Throughput: one byte per 8 valid bits; sustained pop rate of one byte per cycle.
- `rst_n` asserted mid-byte or with a non-empty FIFO discards everything immediately and asynchronously. The first capture is on the first rising edge after deassertion.

## Configuration
- Macro: `SERDES_RX_DECRYPT_EN`.
- Defined: each byte is XORed with KEY_BYTE before the push.
- Undefined: the raw assembled byte is pushed, KEY_BYTE is unused, and there is no XOR logic. All other behaviour is identical.

## Test plan
- Decrypt path: with the macro defined, reset, then feed 8'h9C MSB first with `sin_valid`=1 for 8 edges and `out_ready`=0 → `out_valid` rises one cycle after the 8th edge, `out_data`=8'hA8, `fill`=1. Without the macro, the same stimulus gives `out_data`=8'h9C.
- Overflow: with `FIFO_DEPTH`=4 and `out_ready`=0, send 5 bytes → `fill`=4 and `overflow`=1. Then pop 4 bytes → only the first 4 bytes come out, in order. Pulse `clr_err` → `overflow`=0.
- Full with simultaneous pop: FIFO full, the 8th bit of a byte lands on the same edge as a pop → byte accepted, `fill` stays 4, `overflow` stays 0.
- Timeout: send 3 bits, then hold `sin_valid`=0 for 16 cycles → `frame_err`=1, `fill`=0. The next 8 bits assemble a correct byte.
- Sync: send 5 bits, then assert `sync` with `sin_valid`=1 → counting restarts. Exactly 7 further bits then produce one byte built from the new alignment.
- Reset mid-operation: assert `rst_n`=0 asynchronously with a partial byte in progress and 2 bytes queued → outputs go to their reset values immediately, and after release the first full byte is decoded correctly.

Source files
------------

// File: rtl/secure_serdes_rx_deserializer.sv
// secure_serdes_rx_deserializer
// Reassembles the encryptor's serial cipher stream into bytes, MSB first,
// and buffers them in a show-ahead FIFO with a valid/ready byte interface.
// Flags FIFO overflow and partial bytes discarded by idle timeout.
// Optional feature macro: SERDES_RX_DECRYPT_EN
//   defined   - each assembled byte is XORed with KEY_BYTE before the push
//   undefined - the raw assembled byte is pushed and KEY_BYTE is unused
module secure_serdes_rx_deserializer #(
  parameter logic [7:0] KEY_BYTE   = 8'h34,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       sync,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] fill,
  output logic       overflow,
  output logic       frame_err,
  input  logic       clr_err
);

  localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH5   = 5'(FIFO_DEPTH);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, next_state;
  logic [6:0]      shift_reg;
  logic [2:0]      bit_cnt;
  logic [7:0]      idle_cnt;
  logic            byte_done;
  logic            tmo_hit;
  logic [7:0]      raw_byte;
  logic [7:0]      rx_byte;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [4:0]      count;
  logic            fifo_full;
  logic            pop;
  logic            push_ok;
  logic            ovf_set;

  assign raw_byte = {shift_reg, sin};

`ifdef SERDES_RX_DECRYPT_EN
  assign rx_byte = raw_byte ^ KEY_BYTE;
`else
  logic key_unused;
  assign key_unused = ^KEY_BYTE;
  assign rx_byte    = raw_byte;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: sync beats capture, capture beats timeout
  always_comb begin
    next_state = state;
    byte_done  = 1'b0;
    tmo_hit    = 1'b0;
    if (sync) begin
      next_state = sin_valid ? SHIFT : IDLE;
    end else if (sin_valid) begin
      if (bit_cnt == 3'd7) begin
        byte_done  = 1'b1;
        next_state = IDLE;
      end else begin
        next_state = SHIFT;
      end
    end else if (state == SHIFT && idle_cnt == TMO_LAST) begin
      tmo_hit    = 1'b1;
      next_state = IDLE;
    end
  end

  // Shift register, bit counter and idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
    end else if (sync) begin
      shift_reg <= sin_valid ? {6'b0, sin} : 7'b0;
      bit_cnt   <= sin_valid ? 3'd1 : 3'd0;
      idle_cnt  <= '0;
    end else if (sin_valid) begin
      idle_cnt <= '0;
      if (byte_done) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else begin
        shift_reg <= {shift_reg[5:0], sin};
        bit_cnt   <= bit_cnt + 3'd1;
      end
    end else if (tmo_hit) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
    end else if (state == SHIFT) begin
      idle_cnt <= idle_cnt + 8'd1;
    end else begin
      idle_cnt <= '0;
    end
  end

  assign fifo_full = (count == DEPTH5);
  assign pop       = (count != 5'd0) && out_ready;
  assign push_ok   = byte_done && (!fifo_full || pop);
  assign ovf_set   = byte_done && fifo_full && !pop;

  // FIFO storage; contents need no reset since pointers and count gate them
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set event wins over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_set)      overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
      if (tmo_hit)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  assign out_valid = (count != 5'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign fill      = count;

endmodule

// File: tb/tb_secure_serdes_rx_deserializer.sv
// tb_secure_serdes_rx_deserializer
// Directed bench for secure_serdes_rx_deserializer; expected bytes follow
// the SERDES_RX_DECRYPT_EN setting of the build.
module tb_secure_serdes_rx_deserializer;

  localparam logic [7:0] KEY = 8'h34;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       sync;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] fill;
  logic       overflow;
  logic       frame_err;
  logic       clr_err;

  int n_checks;
  int n_fail;

  secure_serdes_rx_deserializer #(
    .KEY_BYTE  (KEY),
    .FIFO_DEPTH(4),
    .TIMEOUT   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .sin_valid(sin_valid),
    .sync     (sync),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fill     (fill),
    .overflow (overflow),
    .frame_err(frame_err),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dec(input logic [7:0] raw);
`ifdef SERDES_RX_DECRYPT_EN
    return raw ^ KEY;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic pop_one(input string tag, input logic [7:0] exp);
    check(tag, {24'b0, out_data}, {24'b0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  logic [7:0] ovf_bytes [5];
  logic [7:0] full_bytes [5];
  logic [7:0] c3;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    sync      = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;

    // Reset state
    #3;
    check("rst_out_data",  {24'b0, out_data}, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_fill",      {27'b0, fill}, 32'h0);
    check("rst_overflow",  {31'b0, overflow}, 32'h0);
    check("rst_frame_err", {31'b0, frame_err}, 32'h0);
    #9 rst_n = 1'b1;
    tick();

    // Decrypt path: 0x9C, out_valid only after the 8th bit
    for (int i = 7; i >= 1; i--) send_bit(i[0] ? 1'b0 : 1'b0);
    idle(0);
    // the loop above sent seven zeros; realign with sync for the real byte
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("dec_not_yet_valid", {31'b0, out_valid}, 32'h0);
    send_bit(1'b0);
    check("dec_valid", {31'b0, out_valid}, 32'h1);
    check("dec_fill", {27'b0, fill}, 32'h1);
`ifdef SERDES_RX_DECRYPT_EN
    pop_one("dec_data", 8'hA8);
`else
    pop_one("dec_data", 8'h9C);
`endif
    check("dec_empty_fill", {27'b0, fill}, 32'h0);
    check("dec_empty_data", {24'b0, out_data}, 32'h0);

    // Overflow: 5 bytes into a 4-deep FIFO
    ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) send_byte(ovf_bytes[i]);
    check("ovf_not_yet", {31'b0, overflow}, 32'h0);
    send_byte(ovf_bytes[4]);
    check("ovf_fill", {27'b0, fill}, 32'h4);
    check("ovf_flag", {31'b0, overflow}, 32'h1);
    for (int i = 0; i < 4; i++) pop_one($sformatf("ovf_pop%0d", i), dec(ovf_bytes[i]));
    check("ovf_drained", {31'b0, out_valid}, 32'h0);
    check("ovf_sticky", {31'b0, overflow}, 32'h1);
    pulse_clr();
    check("ovf_cleared", {31'b0, overflow}, 32'h0);

    // Full with a pop on the same edge as the 8th bit
    full_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 4; i++) send_byte(full_bytes[i]);
    for (int i = 7; i >= 1; i--) send_bit(full_bytes[4][i]);
    sin       = full_bytes[4][0];
    sin_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    sin_valid = 1'b0;
    out_ready = 1'b0;
    check("fullpop_fill", {27'b0, fill}, 32'h4);
    check("fullpop_ovf", {31'b0, overflow}, 32'h0);
    for (int i = 1; i < 5; i++) pop_one($sformatf("fullpop_pop%0d", i), dec(full_bytes[i]));
    check("fullpop_drained", {27'b0, fill}, 32'h0);

    // Timeout: 3 bits then 16 idle cycles
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    idle(15);
    check("tmo_not_yet", {31'b0, frame_err}, 32'h0);
    idle(1);
    check("tmo_flag", {31'b0, frame_err}, 32'h1);
    check("tmo_fill", {27'b0, fill}, 32'h0);
    send_byte(8'h5A);
    check("tmo_next_valid", {31'b0, out_valid}, 32'h1);
    pop_one("tmo_next_data", dec(8'h5A));
    pulse_clr();
    check("tmo_cleared", {31'b0, frame_err}, 32'h0);

    // Sync: 5 stray bits, then sync with the first bit of 0xC3
    c3 = 8'hC3;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    sync = 1'b1;
    send_bit(c3[7]);
    sync = 1'b0;
    for (int i = 6; i >= 1; i--) send_bit(c3[i]);
    check("sync_not_yet", {31'b0, out_valid}, 32'h0);
    send_bit(c3[0]);
    check("sync_fill", {27'b0, fill}, 32'h1);
    check("sync_err", {31'b0, frame_err}, 32'h0);
    pop_one("sync_data", dec(8'hC3));

    // Reset mid-operation: 2 bytes queued, 4 bits partial, overflow not set
    send_byte(8'h0F);
    send_byte(8'hF0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    check("pre_rst_fill", {27'b0, fill}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'h0);
    check("arst_out_data",  {24'b0, out_data}, 32'h0);
    check("arst_fill",      {27'b0, fill}, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    send_byte(8'h66);
    check("post_rst_fill", {27'b0, fill}, 32'h1);
    pop_one("post_rst_data", dec(8'h66));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
